// File: rtl/finish_overlay.sv
// finish_overlay: game-over banner ROM reader, presentation sequencer (delay/blink/hold) and compositor.
// Optional macro FINISH_DIM_EN halves every background channel during BLINK and HOLD.
module finish_overlay #(
    parameter int          BANNER_W     = 320,
    parameter int          BANNER_H     = 67,
    parameter int          BANNER_X     = 160,
    parameter int          BANNER_Y     = 206,
    parameter int          DELAY_FRAMES = 30,
    parameter int          BLINK_FRAMES = 16,
    parameter int          BLINK_COUNT  = 4,
    parameter logic [11:0] KEY_COLOR    = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic [11:0] bg_rgb,
    input  logic        game_over,
    input  logic        winner,
    input  logic        restart,
    output logic [14:0] rom_addr,
    output logic [2:0]  rom_finish,
    input  logic [11:0] rom_data,
    output logic [11:0] rgb,
    output logic        banner_done
);
    // state | meaning
    // IDLE  | no match end pending, banner hidden
    // DELAY | counting frames after game_over, banner hidden
    // BLINK | banner toggles every BLINK_FRAMES frames
    // HOLD  | banner shown steadily until restart
    typedef enum logic [1:0] {IDLE, DELAY, BLINK, HOLD} state_t;

    localparam logic [9:0] X_LO       = 10'(BANNER_X);
    localparam logic [9:0] X_HI       = 10'(BANNER_X + BANNER_W - 1);
    localparam logic [9:0] Y_LO       = 10'(BANNER_Y);
    localparam logic [9:0] Y_HI       = 10'(BANNER_Y + BANNER_H - 1);
    localparam logic [7:0] DELAY_LAST = 8'(DELAY_FRAMES - 1);
    localparam logic [7:0] HALF_LAST  = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0] BLINK_LAST = 8'(2 * BLINK_COUNT * BLINK_FRAMES - 1);

    state_t      state_q, state_d;
    logic        show_q, show_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  half_cnt_q, half_cnt_d;
    logic        winner_q, winner_d;
    logic        banner_done_q, banner_done_d;
    logic [2:0]  rom_finish_q, rom_finish_d;
    logic [14:0] rom_addr_q, rom_addr_d;
    logic        in_win_d1_q, in_win_d1_d, in_win_d2_q, in_win_d2_d;
    logic        vid_d1_q, vid_d1_d, vid_d2_q, vid_d2_d;
    logic [11:0] bg_d1_q, bg_d1_d, bg_d2_q, bg_d2_d;
    logic [11:0] rgb_q, rgb_d;
    logic        in_win;
    logic [9:0]  dx, dy;
    logic [14:0] dy_w;
    logic [11:0] bg_pix;

    always_comb begin
        state_d     = state_q;
        show_d      = show_q;
        frame_cnt_d = frame_cnt_q;
        half_cnt_d  = half_cnt_q;
        winner_d    = winner_q;
        if (restart) begin
            state_d     = IDLE;
            show_d      = 1'b0;
            frame_cnt_d = '0;
            half_cnt_d  = '0;
            winner_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    show_d = 1'b0;
                    if (game_over) begin
                        winner_d    = winner;
                        state_d     = DELAY;
                        frame_cnt_d = '0;
                        half_cnt_d  = '0;
                    end
                end
                DELAY: if (frame_tick) begin
                    if (frame_cnt_q == DELAY_LAST) begin
                        state_d     = BLINK;
                        show_d      = 1'b1;
                        frame_cnt_d = '0;
                        half_cnt_d  = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
                BLINK: if (frame_tick) begin
                    // half_cnt paces the toggles, frame_cnt bounds the whole blink phase
                    if (half_cnt_q == HALF_LAST) begin
                        show_d     = ~show_q;
                        half_cnt_d = '0;
                    end else begin
                        half_cnt_d = half_cnt_q + 8'd1;
                    end
                    if (frame_cnt_q == BLINK_LAST) begin
                        state_d     = HOLD;
                        show_d      = 1'b1;
                        frame_cnt_d = '0;
                        half_cnt_d  = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
                default: show_d = 1'b1;
            endcase
        end
        rom_finish_d  = {1'b0, winner_d, state_d != IDLE};
        banner_done_d = (state_d == HOLD);
    end

    // Address multiply by 320 is built as (dy << 8) + (dy << 6).
    always_comb begin
        in_win = video_on && (hcount >= X_LO) && (hcount <= X_HI)
                 && (vcount >= Y_LO) && (vcount <= Y_HI);
        dx   = hcount - X_LO;
        dy   = vcount - Y_LO;
        dy_w = {5'b0, dy};
        rom_addr_d  = in_win ? (dy_w << 8) + (dy_w << 6) + {5'b0, dx} : '0;
        in_win_d1_d = in_win;
        vid_d1_d    = video_on;
        bg_d1_d     = bg_rgb;
        in_win_d2_d = in_win_d1_q;
        vid_d2_d    = vid_d1_q;
        bg_d2_d     = bg_d1_q;
    end

    always_comb begin
        bg_pix = bg_d2_q;
`ifdef FINISH_DIM_EN
        if (state_q == BLINK || state_q == HOLD)
            bg_pix = {1'b0, bg_d2_q[11:9], 1'b0, bg_d2_q[7:5], 1'b0, bg_d2_q[3:1]};
`endif
        if (!vid_d2_q)
            rgb_d = '0;
        else if (show_q && in_win_d2_q && rom_data != KEY_COLOR)
            rgb_d = rom_data;
        else
            rgb_d = bg_pix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            show_q        <= 1'b0;
            frame_cnt_q   <= '0;
            half_cnt_q    <= '0;
            winner_q      <= 1'b0;
            banner_done_q <= 1'b0;
            rom_finish_q  <= '0;
            rom_addr_q    <= '0;
            in_win_d1_q   <= 1'b0;
            in_win_d2_q   <= 1'b0;
            vid_d1_q      <= 1'b0;
            vid_d2_q      <= 1'b0;
            bg_d1_q       <= '0;
            bg_d2_q       <= '0;
            rgb_q         <= '0;
        end else begin
            state_q       <= state_d;
            show_q        <= show_d;
            frame_cnt_q   <= frame_cnt_d;
            half_cnt_q    <= half_cnt_d;
            winner_q      <= winner_d;
            banner_done_q <= banner_done_d;
            rom_finish_q  <= rom_finish_d;
            rom_addr_q    <= rom_addr_d;
            in_win_d1_q   <= in_win_d1_d;
            in_win_d2_q   <= in_win_d2_d;
            vid_d1_q      <= vid_d1_d;
            vid_d2_q      <= vid_d2_d;
            bg_d1_q       <= bg_d1_d;
            bg_d2_q       <= bg_d2_d;
            rgb_q         <= rgb_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign rom_finish  = rom_finish_q;
    assign rgb         = rgb_q;
    assign banner_done = banner_done_q;
endmodule

// File: tb/tb_finish_overlay.sv
// tb_finish_overlay: directed stimulus for finish_overlay with a frame-count model and per-cycle output compare.
module tb_finish_overlay;
    localparam int DELAY_FRAMES = 30;
    localparam int BLINK_FRAMES = 16;
    localparam int BLINK_COUNT  = 4;
    localparam int BLINK_TOTAL  = 2 * BLINK_COUNT * BLINK_FRAMES;
`ifdef FINISH_DIM_EN
    localparam logic [11:0] BG246_ACT = 12'h123;
    localparam logic [11:0] BG5A5_ACT = 12'h252;
    localparam logic [11:0] BGFFF_ACT = 12'h777;
`else
    localparam logic [11:0] BG246_ACT = 12'h246;
    localparam logic [11:0] BG5A5_ACT = 12'h5A5;
    localparam logic [11:0] BGFFF_ACT = 12'hFFF;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  hcount = '0, vcount = '0;
    logic        video_on = 1'b0, frame_tick = 1'b0, game_over = 1'b0, winner = 1'b0, restart = 1'b0;
    logic [11:0] bg_rgb = '0, rom_data = '0;
    logic [14:0] rom_addr;
    logic [2:0]  rom_finish;
    logic [11:0] rgb;
    logic        banner_done;

    int n_cmp = 0;
    int n_bad = 0;

    finish_overlay dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .video_on(video_on),
        .frame_tick(frame_tick), .bg_rgb(bg_rgb), .game_over(game_over), .winner(winner),
        .restart(restart), .rom_addr(rom_addr), .rom_finish(rom_finish), .rom_data(rom_data),
        .rgb(rgb), .banner_done(banner_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Banner ROM contents: even addresses transparent, odd ones a red-family colour.
    function automatic logic [11:0] rom_fn(input logic [14:0] a);
        if (a[0] == 1'b0) return 12'h000;
        return 12'hF00 | {4'h0, a[7:0] & 8'hFE};
    endfunction

    logic [14:0] rom_prev = '0;
    always @(negedge clk) begin
        rom_data = rom_fn(rom_prev);
        rom_prev = rom_addr;
    end

    typedef struct packed {
        logic       vo;
        logic [9:0] h;
        logic [9:0] v;
        logic [11:0] bg;
    } pix_t;

    function automatic bit m_in_win(input pix_t p);
        return p.vo && int'(p.h) >= 160 && int'(p.h) <= 479 && int'(p.v) >= 206 && int'(p.v) <= 272;
    endfunction

    function automatic int m_addr(input pix_t p);
        if (!m_in_win(p)) return 0;
        return (int'(p.v) - 206) * 320 + (int'(p.h) - 160);
    endfunction

    function automatic bit m_show(input bit act, input int t);
        if (!act || t < DELAY_FRAMES) return 1'b0;
        if (t - DELAY_FRAMES >= BLINK_TOTAL) return 1'b1;
        return ((t - DELAY_FRAMES) / BLINK_FRAMES) % 2 == 0;
    endfunction

    function automatic logic [11:0] m_pixel(input pix_t p, input bit sh, input bit dim);
        logic [11:0] r;
        r = rom_fn(15'(m_addr(p)));
        if (!p.vo) return 12'h000;
        if (sh && m_in_win(p) && r != 12'h000) return r;
`ifdef FINISH_DIM_EN
        if (dim) return {1'b0, p.bg[11:9], 1'b0, p.bg[7:5], 1'b0, p.bg[3:1]};
`endif
        return p.bg;
    endfunction

    pix_t p1 = '0, p2 = '0;
    bit   m_active = 1'b0, m_winner = 1'b0, chk_en = 1'b0;
    int   m_ticks = 0;

    always @(posedge clk) begin
        pix_t        now;
        logic [11:0] e_rgb;
        logic [14:0] e_addr;
        logic [2:0]  e_fin;
        logic        e_done;
        now.vo = rst ? 1'b0 : video_on;
        now.h  = hcount;
        now.v  = vcount;
        now.bg = bg_rgb;
        e_rgb  = rst ? 12'h000 : m_pixel(p2, m_show(m_active, m_ticks), m_active && m_ticks >= DELAY_FRAMES);
        e_addr = 15'(m_addr(now));
        p2 = p1;
        p1 = now;
        if (rst || restart) begin
            m_active = 1'b0; m_winner = 1'b0; m_ticks = 0;
        end else if (!m_active && game_over) begin
            m_active = 1'b1; m_winner = winner; m_ticks = 0;
        end else if (m_active && frame_tick) begin
            m_ticks++;
        end
        e_fin  = {1'b0, m_winner, m_active};
        e_done = m_active && m_ticks >= DELAY_FRAMES + BLINK_TOTAL;
        if (rst) chk_en = 1'b1;
        #1;
        if (chk_en) begin
            chk("cyc_rgb", 32'(rgb), 32'(e_rgb));
            chk("cyc_rom_addr", 32'(rom_addr), 32'(e_addr));
            chk("cyc_rom_finish", 32'(rom_finish), 32'(e_fin));
            chk("cyc_banner_done", 32'(banner_done), 32'(e_done));
        end
    end

    task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic vo, input logic [11:0] bg,
                         input logic ft, input logic go, input logic w, input logic rs);
        hcount = h; vcount = v; video_on = vo; bg_rgb = bg;
        frame_tick = ft; game_over = go; winner = w; restart = rs;
        @(negedge clk);
    endtask

    task automatic blank();
        drive(10'd0, 10'd0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        drive(10'd0, 10'd0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic [11:0] bg);
        drive(h, v, 1'b1, bg, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic probe(input string name, input logic [9:0] h, input logic [9:0] v, input logic [11:0] bg,
                         input logic [14:0] exp_addr, input logic [11:0] exp_rgb);
        pix(h, v, bg);
        chk({name, "_addr"}, 32'(rom_addr), 32'(exp_addr));
        blank();
        blank();
        chk({name, "_rgb"}, 32'(rgb), 32'(exp_rgb));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; video_on = 1'b1; bg_rgb = 12'hABC;
        repeat (3) @(negedge clk);
        chk("rst_rgb", 32'(rgb), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_rom_finish", 32'(rom_finish), 32'h0);
        chk("rst_banner_done", 32'(banner_done), 32'h0);
        rst = 1'b0;

        pix(10'd10, 10'd10, 12'hABC);
        pix(10'd11, 10'd10, 12'h123);
        pix(10'd12, 10'd10, 12'h123);
        chk("idle_latency", 32'(rgb), 32'hABC);
        pix(10'd13, 10'd10, 12'h123);
        chk("idle_next", 32'(rgb), 32'h123);
        repeat (3) drive(10'd20, 10'd20, 1'b0, 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("blank_rgb", 32'(rgb), 32'h0);
        probe("idle_win", 10'd161, 10'd206, 12'h246, 15'd1, 12'h246);

        drive(10'd0, 10'd0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("go_rom_finish", 32'(rom_finish), 32'h3);
        chk("go_banner_done", 32'(banner_done), 32'h0);

        for (int t = 1; t <= 160; t++) begin
            tick();
            pix(10'd161, 10'd206, 12'h246);
            blank();
            blank();
            case (t)
                29:  chk("t29_hidden", 32'(rgb), 32'h246);
                30:  chk("t30_shown", 32'(rgb), 32'hF00);
                45:  chk("t45_shown", 32'(rgb), 32'hF00);
                46:  chk("t46_hidden", 32'(rgb), 32'(BG246_ACT));
                61:  chk("t61_hidden", 32'(rgb), 32'(BG246_ACT));
                62:  chk("t62_shown", 32'(rgb), 32'hF00);
                157: begin
                    chk("t157_hidden", 32'(rgb), 32'(BG246_ACT));
                    chk("t157_not_done", 32'(banner_done), 32'h0);
                end
                158: begin
                    chk("t158_hold", 32'(rgb), 32'hF00);
                    chk("t158_done", 32'(banner_done), 32'h1);
                end
                default: ;
            endcase
        end

        probe("hold_origin", 10'd160, 10'd206, 12'h5A5, 15'd0, BG5A5_ACT);
        probe("hold_opaque", 10'd161, 10'd206, 12'h5A5, 15'd1, 12'hF00);
        probe("hold_last", 10'd479, 10'd272, 12'h5A5, 15'd21439, 12'hFBE);
        probe("hold_right", 10'd480, 10'd206, 12'hFFF, 15'd0, BGFFF_ACT);
        probe("hold_left", 10'd159, 10'd206, 12'h5A5, 15'd0, BG5A5_ACT);
        probe("hold_above", 10'd160, 10'd205, 12'h5A5, 15'd0, BG5A5_ACT);
        probe("hold_below", 10'd160, 10'd273, 12'h5A5, 15'd0, BG5A5_ACT);
        probe("hold_row2", 10'd163, 10'd207, 12'h5A5, 15'd323, 12'hF42);
        drive(10'd0, 10'd0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("hold_go_ignored", 32'(rom_finish), 32'h3);

        drive(10'd0, 10'd0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("rs_rom_finish", 32'(rom_finish), 32'h0);
        chk("rs_banner_done", 32'(banner_done), 32'h0);
        probe("rs_idle_win", 10'd161, 10'd206, 12'h246, 15'd1, 12'h246);

        drive(10'd0, 10'd0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("go2_rom_finish", 32'(rom_finish), 32'h1);
        repeat (3) tick();
        drive(10'd0, 10'd0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("delay_go_ignored", 32'(rom_finish), 32'h1);
        repeat (2) tick();
        drive(10'd0, 10'd0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rs_tick_finish", 32'(rom_finish), 32'h0);

        drive(10'd0, 10'd0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("go3_rom_finish", 32'(rom_finish), 32'h3);
        repeat (35) tick();
        probe("blink_again", 10'd161, 10'd206, 12'h246, 15'd1, 12'hF00);
        rst = 1'b1;
        blank();
        rst = 1'b0;
        chk("midrst_finish", 32'(rom_finish), 32'h0);
        probe("post_rst", 10'd161, 10'd206, 12'h246, 15'd1, 12'h246);

        repeat (3) blank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/finish_overlay.md
Name: finish_overlay

Overview:
Reader side of the game-over banner ROM. It turns VGA scan coordinates into banner ROM addresses and winner-select bits. It also sequences the end-of-match presentation: a delay, then a blink phase, then a steady hold. It composites the returned ROM pixels over the game background and sits between the game FSM / VGA timing and the final RGB output register.

Parameters:
BANNER_W, 320, banner width in pixels
BANNER_H, 67, banner height in pixels
BANNER_X, 160, left column of banner on 640x480 screen
BANNER_Y, 206, top row of banner
DELAY_FRAMES, 30, frames between game_over and first banner display
BLINK_FRAMES, 16, frames per blink half-period
BLINK_COUNT, 4, number of on/off blink pairs before hold
KEY_COLOR, 12'h000, ROM pixel value treated as transparent

Ports:
clk  in  1  system/pixel clock
rst  in  1  synchronous, active-high reset
hcount  in  10  current pixel column
vcount  in  10  current pixel row
video_on  in  1  visible-area flag, aligned with hcount/vcount
frame_tick  in  1  one-cycle pulse at start of vertical blank
bg_rgb  in  12  background pixel, aligned with hcount/vcount
game_over  in  1  one-cycle pulse from game FSM
winner  in  1  0 = P1 wins, 1 = P2 wins; sampled with game_over
restart  in  1  one-cycle pulse; return to idle
rom_addr  out  15  banner ROM address, registered
rom_finish  out  3  banner ROM select {1'b0, winner_latched, active}, registered
rom_data  in  12  ROM pixel; valid one cycle after rom_addr
rgb  out  12  composited pixel, registered
banner_done  out  1  high while in HOLD

Behaviour:
- Reset (rst=1 at clk edge) sets:
  - rom_addr=0, rom_finish=0, rgb=0, banner_done=0.
  - state=IDLE, show=0, counters=0, winner_latched=0.
- States: IDLE, DELAY, BLINK, HOLD.
- IDLE:
  - show=0.
  - On game_over: latch winner, go to DELAY, clear frame counter.
- DELAY:
  - Count frame_tick pulses.
  - On the DELAY_FRAMES-th tick: go to BLINK, set show=1, clear counter.
- BLINK:
  - Count frame_tick pulses; show toggles every BLINK_FRAMES ticks.
  - After 2*BLINK_COUNT*BLINK_FRAMES ticks: go to HOLD, set show=1.
- HOLD:
  - show=1, banner_done=1.
  - Remain in HOLD until restart.
- restart in any state: go to IDLE next cycle, clear show, counters, banner_done and winner_latched.
  - restart has priority over game_over and frame_tick in the same cycle.
- game_over outside IDLE is ignored; winner is not re-latched.
- show changes only on frame_tick edges, so there is no mid-frame tearing; restart is the sole exception.
- rom_finish = {1'b0, winner_latched, state!=IDLE}.
- Window: in_win = video_on && hcount in [BANNER_X, BANNER_X+BANNER_W-1] && vcount in [BANNER_Y, BANNER_Y+BANNER_H-1].
- Address:
  - rom_addr = (vcount-BANNER_Y)*BANNER_W + (hcount-BANNER_X) when in_win, else 0.
  - Computed in 15 bits with shift-add (x320 = <<8 + <<6); maximum value 21439.
  - Registered at the edge after hcount/vcount are presented.
- Pipeline:
  - Inputs are presented in cycle N.
  - rom_addr is valid in N+1; rom_data is valid in N+2.
  - rgb is registered at the end of N+2 and is valid in N+3. Total latency is fixed at 3 cycles.
  - bg_rgb, in_win and video_on are delayed by 2 registers to align with rom_data.
- Compositing, in priority order at the rgb register:
  - delayed video_on=0 → rgb=0.
  - show && in_win_d && rom_data!=KEY_COLOR → rgb=rom_data.
  - otherwise → rgb=bg_rgb_d.
- Frame counter is 8 bits wide, sized for the default parameters. Parameter values beyond 255 total frames per phase are unsupported.

Optional Feature:
- Macro FINISH_DIM_EN.
- Defined: in BLINK and HOLD, every non-banner visible pixel is dimmed. This applies outside the window, on transparent pixels, and during show=0 halves. Each 4-bit channel of bg_rgb_d is shifted right by 1.
- Not defined: the background passes through unchanged in all states.
- Latency is identical either way.

Test Plan:
1. Reset, then IDLE with video_on=1 and bg_rgb=12'hABC → rgb=12'hABC exactly 3 cycles later. Outputs read 0 during reset; with video_on=0, rgb=0.
2. In HOLD:
   - hcount=160, vcount=206 → rom_addr=0 one cycle later.
   - (479, 272) → rom_addr=21439.
   - (480, 206) → rom_addr=0 and rgb=bg_rgb.
3. game_over with winner=1 → rom_finish=3'b011.
   - Banner absent for ticks 1-30; visible after tick 30 through tick 46; hidden until tick 62; and so on.
   - HOLD and banner_done=1 after tick 158.
4. Transparency in HOLD, in window:
   - rom_data=12'h000 → rgb=bg_rgb.
   - rom_data=12'hF00 → rgb=12'hF00.
5. In HOLD, restart and game_over in the same cycle → IDLE next cycle, banner_done=0, rom_finish=0. A second game_over during DELAY leaves winner_latched unchanged.
6. FINISH_DIM_EN defined, HOLD, bg_rgb=12'hFFF outside window → rgb=12'h777. Undefined → rgb=12'hFFF.
